// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and FSM encoding for the backing-memory path
package mem_pkg;
  localparam int WORD_W = 32;
  localparam int LINE_WORDS = 4;
  localparam int DEF_LATENCY = 4;
  localparam int DEF_DEPTH_LOG2 = 10;
  localparam logic S_READY = 1'b0;
  localparam logic S_BUSY = 1'b1;
endpackage

// File: rtl/ram_array.sv
// ram_array: single-port synchronous word array, registered read
module ram_array
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);
  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: fixed-latency single-word RAM controller behind the cache RAM port
module ram_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int LATENCY = DEF_LATENCY,
  parameter INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_cs,
  input  logic              ram_we,
  input  logic [31:0]       ram_addr,
  input  logic [WORD_W-1:0] ram_din,
  output logic [WORD_W-1:0] ram_dout,
  output logic              ram_ack,
  output logic              ram_stall
);
  logic                  state;
  logic [3:0]            lat_cnt;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [WORD_W-1:0]     din_q;
  logic [WORD_W-1:0]     rd_data;
  logic [DEPTH_LOG2-1:0] idx_in;
  logic [DEPTH_LOG2-1:0] arr_addr;
  logic                  done;
  logic                  unused_addr;
  assign idx_in = ram_addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^{ram_addr[31:DEPTH_LOG2+2], ram_addr[1:0]};
  assign done = (state == S_BUSY) && (lat_cnt == 4'd0);
  // in READY the array pre-reads the incoming index so data is ready even at LATENCY=1
  assign arr_addr = (state == S_READY) ? idx_in : idx_q;
  assign ram_ack = (state == S_READY);
  assign ram_stall = ~ram_ack;
  ram_array #(.DEPTH_LOG2(DEPTH_LOG2), .INIT_FILE(INIT_FILE)) u_array (
    .clk  (clk),
    .we   (done & we_q),
    .addr (arr_addr),
    .wdata(din_q),
    .rdata(rd_data)
  );
  // accept in READY, count down in BUSY, commit or capture read data on the last edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_READY;
      lat_cnt <= 4'd0;
      ram_dout <= '0;
      we_q <= 1'b0;
      idx_q <= '0;
      din_q <= '0;
    end else if (state == S_READY) begin
      if (ram_cs) begin
        state <= S_BUSY;
        lat_cnt <= 4'(LATENCY - 1);
        we_q <= ram_we;
        idx_q <= idx_in;
        din_q <= ram_din;
      end
    end else if (lat_cnt != 4'd0) begin
      lat_cnt <= lat_cnt - 4'd1;
    end else begin
      state <= S_READY;
      if (!we_q) ram_dout <= rd_data;
    end
  end
endmodule
